// File: rtl/clk_div_multi_pkg.sv
// Shared definitions for the multi-channel clock divider: channel state
// encoding, default widths and the high-phase length helper.
// Optional feature macro: CLK_DIV_MULTI_DUTY50_EN (50% duty for odd divisors).
package clk_div_multi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    BYPASS = 2'd2
  } ch_state_t;

  localparam int DIV_W_DEF  = 8;
  localparam int NUM_CH_DEF = 4;

`ifdef CLK_DIV_MULTI_DUTY50_EN
  localparam logic DUTY50 = 1'b1;
`else
  localparam logic DUTY50 = 1'b0;
`endif

  // Number of cycles out_q stays high within one period. In duty50 mode odd
  // divisors get one cycle less; the falling-edge flop adds the missing half.
  function automatic logic [15:0] high_len(input logic [15:0] d_act,
                                           input logic        duty50);
    logic [15:0] h;
    if (duty50 && d_act[0] && (d_act >= 16'd3)) begin
      h = (d_act - 16'd1) >> 1;
    end else begin
      h = (d_act >> 1) + {15'd0, d_act[0]};
    end
    return h;
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: IDLE / RUN / BYPASS state machine with divisor loads
// only at period boundaries and a falling-edge gate for glitch-free bypass.
// Optional feature macro: CLK_DIV_MULTI_DUTY50_EN adds a falling-edge copy of
// out_q so odd divisors produce a 50% duty clock.
module clk_div_channel
  import clk_div_multi_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [DIV_W-1:0] div,
  input  logic             sync,
  output logic             clk_out,
  output logic             tick,
  output logic             running
);

  ch_state_t        state_r;
  logic [DIV_W-1:0] cnt_r;
  logic [DIV_W-1:0] d_act_r;
  logic             out_q_r;
  logic             tick_r;
  logic             running_r;
  logic             gate_r;
  logic             run_clk_s;

  logic             wrap_s;
  logic             load_s;
  logic             stop_s;
  logic [DIV_W-1:0] d_last_s;
  logic [15:0]      h_s;
  logic [15:0]      cnt_nxt_s;

  assign d_last_s  = d_act_r - {{(DIV_W-1){1'b0}}, 1'b1};
  assign h_s       = high_len(16'(d_act_r), DUTY50);
  assign cnt_nxt_s = 16'(cnt_r) + 16'd1;

  // Decide whether this edge loads a new divisor or drops back to IDLE.
  always_comb begin
    wrap_s = (state_r == RUN) && (cnt_r == d_last_s);
    load_s = 1'b0;
    stop_s = 1'b0;
    if (enable && sync) begin
      load_s = 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          load_s = enable;
        end
        RUN: begin
          if (wrap_s) begin
            load_s = enable;
            stop_s = ~enable;
          end else begin
            load_s = 1'b0;
          end
        end
        BYPASS: begin
          load_s = enable;
          stop_s = ~enable;
        end
        default: begin
          stop_s = 1'b1;
        end
      endcase
    end
  end

  // Channel state machine with registered out_q, tick and running.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      d_act_r   <= '0;
      out_q_r   <= 1'b0;
      tick_r    <= 1'b0;
      running_r <= 1'b0;
    end else if (load_s) begin
      d_act_r <= div;
      cnt_r   <= '0;
      if (div == '0) begin
        state_r   <= IDLE;
        out_q_r   <= 1'b0;
        tick_r    <= 1'b0;
        running_r <= 1'b0;
      end else if (div == {{(DIV_W-1){1'b0}}, 1'b1}) begin
        state_r   <= BYPASS;
        out_q_r   <= 1'b0;
        tick_r    <= 1'b1;
        running_r <= 1'b1;
      end else begin
        state_r   <= RUN;
        out_q_r   <= 1'b1;
        tick_r    <= 1'b1;
        running_r <= 1'b1;
      end
    end else if (stop_s) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      out_q_r   <= 1'b0;
      tick_r    <= 1'b0;
      running_r <= 1'b0;
    end else if (state_r == RUN) begin
      cnt_r     <= cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
      out_q_r   <= (cnt_nxt_s < h_s);
      tick_r    <= 1'b0;
      running_r <= 1'b1;
    end else begin
      out_q_r   <= 1'b0;
      tick_r    <= 1'b0;
      running_r <= 1'b0;
    end
  end

  // Bypass gate follows the state on the falling edge so clk_out never runts.
  always_ff @(negedge clk) begin
    if (!reset_n) begin
      gate_r <= 1'b0;
    end else begin
      gate_r <= (state_r == BYPASS);
    end
  end

`ifdef CLK_DIV_MULTI_DUTY50_EN
  logic out_q_neg_r;

  // Half-cycle delayed copy of out_q that stretches odd-divisor high phases.
  always_ff @(negedge clk) begin
    if (!reset_n) begin
      out_q_neg_r <= 1'b0;
    end else begin
      out_q_neg_r <= out_q_r;
    end
  end

  assign run_clk_s = out_q_r | (out_q_neg_r & d_act_r[0] & (state_r == RUN));
`else
  assign run_clk_s = out_q_r;
`endif

  assign clk_out = run_clk_s | (clk & gate_r);
  assign tick    = tick_r;
  assign running = running_r;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel clock divider top: NUM_CH independent channels sharing clk,
// reset_n and the phase-alignment sync pulse.
// Optional feature macro: CLK_DIV_MULTI_DUTY50_EN (handled in each channel).
module clk_div_multi
  import clk_div_multi_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_CH-1:0]       enable,
  input  logic [NUM_CH*DIV_W-1:0] div,
  input  logic                    sync,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       running
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_channel #(
      .DIV_W (DIV_W)
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .enable  (enable[i]),
      .div     (div[i*DIV_W +: DIV_W]),
      .sync    (sync),
      .clk_out (clk_out[i]),
      .tick    (tick[i]),
      .running (running[i])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: period-level reference model checked
// on both clock halves every cycle, plus hand-computed directed sequences.
module tb_clk_div_multi;

  localparam int NCH = 4;
  localparam int DW  = 8;

  logic              clk;
  logic              reset_n;
  logic [NCH-1:0]    enable;
  logic [NCH*DW-1:0] div;
  logic              sync;
  logic [NCH-1:0]    clk_out;
  logic [NCH-1:0]    tick;
  logic [NCH-1:0]    running;

  int n_chk  = 0;
  int n_fail = 0;

  clk_div_multi #(.NUM_CH(NCH), .DIV_W(DW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .div     (div),
    .sync    (sync),
    .clk_out (clk_out),
    .tick    (tick),
    .running (running)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (period arithmetic) ----------------
  int     m_mode  [NCH];   // 0 stopped, 1 divided, 2 pass-through
  int     m_d     [NCH];
  longint m_start [NCH];
  bit     m_out   [NCH];
  bit     m_tick  [NCH];
  bit     m_gate  [NCH];
  bit     m_outn  [NCH];
  longint cyc = 0;
  bit     chk_on = 1'b0;

  function automatic int high_cycles(input int d);
`ifdef CLK_DIV_MULTI_DUTY50_EN
    if ((d % 2) == 1 && d >= 3) return d / 2;
`endif
    return d - d / 2;
  endfunction

  initial begin
    for (int c = 0; c < NCH; c++) begin
      m_mode[c] = 0; m_d[c] = 0; m_start[c] = 0;
      m_out[c] = 1'b0; m_tick[c] = 1'b0; m_gate[c] = 1'b0; m_outn[c] = 1'b0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int c = 0; c < NCH; c++) begin
        int  dv;
        bit  ld, st;
        dv = int'(div[c*DW +: DW]);
        ld = 1'b0;
        st = 1'b0;
        if (!reset_n) begin
          m_mode[c] = 0; m_out[c] = 1'b0; m_tick[c] = 1'b0;
        end else begin
          if (enable[c] && sync) ld = 1'b1;
          else if (m_mode[c] == 0) ld = enable[c];
          else if (m_mode[c] == 2) begin ld = enable[c]; st = !enable[c]; end
          else if ((cyc - m_start[c]) >= m_d[c]) begin ld = enable[c]; st = !enable[c]; end
          if (ld) begin
            m_d[c]     = dv;
            m_mode[c]  = (dv == 0) ? 0 : ((dv == 1) ? 2 : 1);
            m_start[c] = cyc;
            m_tick[c]  = (dv != 0);
          end else begin
            m_tick[c] = 1'b0;
            if (st) m_mode[c] = 0;
          end
          m_out[c] = (m_mode[c] == 1) && ((cyc - m_start[c]) < high_cycles(m_d[c]));
        end
      end
      if (cyc >= 3) chk_on = 1'b1;
      #1;
      if (chk_on) begin
        for (int c = 0; c < NCH; c++) begin
          bit e;
          e = m_out[c] | m_gate[c];
`ifdef CLK_DIV_MULTI_DUTY50_EN
          e = e | (m_outn[c] && m_mode[c] == 1 && (m_d[c] % 2) == 1);
`endif
          chk($sformatf("model_clk_hi[%0d]", c), clk_out[c], e);
          chk($sformatf("model_tick[%0d]", c), tick[c], m_tick[c]);
          chk($sformatf("model_running[%0d]", c), running[c], m_mode[c] != 0);
        end
      end
      @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
        m_gate[c] = reset_n && (m_mode[c] == 2);
        m_outn[c] = reset_n && m_out[c];
      end
      #1;
      if (chk_on) begin
        for (int c = 0; c < NCH; c++) begin
          chk($sformatf("model_clk_lo[%0d]", c), clk_out[c], m_out[c]);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic set_div(input int c, input int v);
    div[c*DW +: DW] = DW'(v);
  endtask

  initial begin
    reset_n = 1'b0;
    enable  = '0;
    div     = '0;
    sync    = 1'b0;
    repeat (4) step();
    for (int c = 0; c < NCH; c++) begin
      chk("reset_clk_out", clk_out[c], 1'b0);
      chk("reset_tick", tick[c], 1'b0);
      chk("reset_running", running[c], 1'b0);
    end
    reset_n = 1'b1;
    step();

    // ch0 d=4: high 2 / low 2, first tick on the edge that samples enable
    set_div(0, 4);
    enable[0] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      chk("d4_clk", clk_out[0], (k % 4) < 2);
      chk("d4_tick", tick[0], (k % 4) == 0);
      chk("d4_running", running[0], 1'b1);
    end

    // ch1 d=5 free running (model covers duty mode)
    set_div(1, 5);
    enable[1] = 1'b1;
    repeat (15) step();

    // ch0: change div to 6 at cnt=1, current period stays 4
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("sync_tick0", tick[0], 1'b1);
    chk("sync_tick1", tick[1], 1'b1);
    step();
    set_div(0, 6);
    for (int k = 0; k < 14; k++) begin
      step();
      chk("div_change_clk", clk_out[0], (k < 2) ? 1'b0 : (((k - 2) % 6) < 3));
      chk("div_change_tick", tick[0], (k >= 2) && (((k - 2) % 6) == 0));
    end

    // ch0 d=6: drop enable at cnt=1, period completes then stops
    sync = 1'b1;
    step();
    sync = 1'b0;
    step();
    enable[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("stop_clk", clk_out[0], k == 0);
      chk("stop_running", running[0], k < 4);
      chk("stop_tick", tick[0], 1'b0);
    end

    // ch0 d=3, ch1 d=6, ch3 d=0 (stays idle), then sync aligns them
    set_div(0, 3);
    set_div(1, 6);
    set_div(3, 0);
    enable[0] = 1'b1;
    enable[3] = 1'b1;
    repeat (4) step();
    chk("d0_idle_running", running[3], 1'b0);
    sync = 1'b1;
    for (int k = 0; k < 18; k++) begin
      step();
      sync = 1'b0;
      chk("align_tick0", tick[0], (k % 3) == 0);
      chk("align_tick1", tick[1], (k % 6) == 0);
      chk("d0_idle_tick", tick[3], 1'b0);
    end

    // ch2 bypass, then back to divide-by-4, then reset mid-period
    enable[0] = 1'b0;
    enable[1] = 1'b0;
    enable[3] = 1'b0;
    set_div(2, 1);
    enable[2] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("bypass_tick", tick[2], 1'b1);
      chk("bypass_running", running[2], 1'b1);
    end
    set_div(2, 4);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("post_bypass_clk", clk_out[2], (k % 4) < 2);
    end
    reset_n = 1'b0;
    step();
    for (int c = 0; c < NCH; c++) begin
      chk("midrun_reset_clk", clk_out[c], 1'b0);
      chk("midrun_reset_tick", tick[c], 1'b0);
      chk("midrun_reset_running", running[c], 1'b0);
    end
    reset_n = 1'b1;
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Parametrised, multi-channel successor to the CPLD single-channel clock divider.
- Each of NUM_CH channels divides clk by its own runtime divisor of DIV_W bits.
- Divisor changes take effect only at period boundaries; start and stop are glitch-free.
- A common sync input phase-aligns all channels; per-channel tick strobes let single-clock logic act on output edges.

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16)
- DIV_W, 8, divisor width in bits (2..16)

Ports:
- clk  in  1  system clock; only clock in the block
- reset_n  in  1  synchronous, active-low reset, sampled on rising clk
- enable  in  NUM_CH  per-channel run request
- div  in  NUM_CH*DIV_W  per-channel divisor; channel i uses bits [i*DIV_W +: DIV_W]
- sync  in  1  one-cycle pulse; restarts all running channels in phase
- clk_out  out  NUM_CH  divided clock per channel
- tick  out  NUM_CH  one-clk strobe, high in the cycle clk_out rises
- running  out  NUM_CH  channel is in RUN or BYPASS

Behaviour:
- Reset (reset_n low at posedge): every channel goes to IDLE; cnt=0, d_act=0, out_q=0, gate=0; clk_out=0, tick=0, running=0. Reset mid-period is honoured at the next posedge with no completion of the period.
- Per-channel states: IDLE, RUN, BYPASS.
- Load event: the current div slice is captured into d_act.
  - d=0: stay in or return to IDLE.
  - d=1: BYPASS.
  - d>=2: RUN.
- IDLE: a posedge with enable=1 triggers a load.
  - Same edge: cnt=0, out_q=1, tick=1 when d>=2.
  - clk_out therefore rises one clk after enable is first sampled high.
- RUN:
  - cnt counts 0..d_act-1 and wraps.
  - out_q=1 iff cnt<H. H=ceil(d_act/2) without the optional feature.
  - clk_out period is exactly d_act clk cycles.
- Wrap (cnt==d_act-1):
  - enable=1: load again; divisor changes apply only here, so no shortened or stretched periods.
  - enable=0: go to IDLE with out_q=0. The current period always completes.
- BYPASS:
  - clk_out = clk AND gate; gate is a flop updated on the falling edge of clk, synchronous reset.
  - Every posedge is a period boundary. Load on each posedge while enable=1; tick=1 every cycle.
  - gate follows (state==BYPASS) at the falling edge, so clk_out never produces a runt pulse entering or leaving bypass.
- sync=1 at posedge:
  - Every channel with enable=1 (any state) reloads, with cnt=0, out_q=1, tick=1.
  - Channels with enable=0 are unaffected.
  - sync takes priority over a simultaneous wrap (identical result) and over a normal IDLE start.
- tick is registered and coincides with the first clk cycle of each clk_out high phase.
- running is the registered state decode.
- div may change at any time; only the value present at a load event is used.

Optional Feature:
- Macro CLK_DIV_MULTI_DUTY50_EN.
- Defined:
  - Odd d_act>=3 uses H=(d_act-1)/2.
  - A falling-edge flop captures out_q; for odd divisors, clk_out = out_q OR out_q_neg.
  - Result: high and low phases of d_act/2 cycles each (50% duty). Even divisors are unchanged.
- Undefined: no falling-edge flop for RUN; odd divisors give high ceil(d/2), low floor(d/2).

Decomposition:
- Package clk_div_multi_pkg: state encoding constants (IDLE, RUN, BYPASS), DIV_W default, and a function computing H from d_act and the duty mode.
- One sub-module, clk_div_channel: a single channel with scalar ports.
- The top generates NUM_CH instances and fans out sync and reset_n.

Test Plan:
- Reset, then ch0 enable=1, d=4 -> clk_out high 2 / low 2, period 4; first tick one clk after enable is sampled; running=1.
- ch1 d=5, macro undefined -> high 3 / low 2. Macro defined -> rising edges 5 clk apart, high time 2.5 clk measured from clk_out rise to fall.
- ch0 d=4, change div to 6 at cnt=1 -> current period stays 4 clk; next period 6 clk with high 3.
- ch0 d=6, drop enable at cnt=1 -> period completes; clk_out low from the wrap onward; running=0; no further ticks.
- ch0 d=3 and ch1 d=6 running free, pulse sync -> both tick in the same cycle; every 6 clk afterwards both rise together.
- ch2 d=1 -> clk_out equals clk with no runt pulses. Switch to d=4 -> first divided period starts cleanly. reset_n=0 mid-run -> all outputs 0 at the next posedge.
